// File: rtl/prf_pkg.sv
// Shared types and constants for the physical register file / ready scoreboard.
// Optional parity protection in prf_scbd is enabled by defining PRF_PARITY_EN.
package prf_pkg;

   localparam int PRF_DEPTH_DFLT = 64;
   localparam int XLEN_DFLT      = 64;
   localparam int PRF_IDX        = $clog2(PRF_DEPTH_DFLT);

   typedef logic [PRF_IDX-1:0]   prf_addr_t;
   typedef logic [XLEN_DFLT-1:0] xdata_t;

   localparam prf_addr_t ZERO_REG = '0;

endpackage

// File: rtl/prf_wr_sel.sv
// Matches one address against every writeback port; the highest enabled port index wins.
module prf_wr_sel #(
   parameter int XLEN    = 64,
   parameter int NUM_WR  = 2,
   parameter int PRF_IDX = 6
) (
   input  logic [PRF_IDX-1:0]             addr,
   input  logic [NUM_WR-1:0]              wr_en,
   input  logic [NUM_WR-1:0][PRF_IDX-1:0] wr_addr,
   input  logic [NUM_WR-1:0][XLEN-1:0]    wr_data,
   output logic                           hit,
   output logic [XLEN-1:0]                data
);

   // later ports overwrite earlier matches, giving highest-index priority
   always_comb begin
      logic m;
      hit  = 1'b0;
      data = '0;
      m    = 1'b0;
      for (int j = 0; j < NUM_WR; j++) begin
         m    = wr_en[j] && (wr_addr[j] == addr);
         hit  = hit | m;
         data = m ? wr_data[j] : data;
      end
   end

endmodule

// File: rtl/prf_scbd.sv
// Physical register file with integrated ready scoreboard and registered read ports.
// Define PRF_PARITY_EN to add per-entry even parity and the rd_perr output.
module prf_scbd #(
   parameter  int XLEN      = 64,
   parameter  int PRF_DEPTH = 64,
   parameter  int NUM_RD    = 4,
   parameter  int NUM_WR    = 2,
   parameter  int NUM_ALLOC = 2,
   localparam int PRF_IDX   = $clog2(PRF_DEPTH)
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_RD-1:0][PRF_IDX-1:0]    rd_addr,
   output logic [NUM_RD-1:0][XLEN-1:0]       rd_data,
   output logic [NUM_RD-1:0]                 rd_rdy,
   input  logic [NUM_WR-1:0]                 wr_en,
   input  logic [NUM_WR-1:0][PRF_IDX-1:0]    wr_addr,
   input  logic [NUM_WR-1:0][XLEN-1:0]       wr_data,
   input  logic [NUM_ALLOC-1:0]              alloc_en,
   input  logic [NUM_ALLOC-1:0][PRF_IDX-1:0] alloc_addr,
   input  logic                              flush,
   output logic                              wr_conflict
`ifdef PRF_PARITY_EN
   ,
   output logic [NUM_RD-1:0]                 rd_perr
`endif
);

   import prf_pkg::ZERO_REG;

   localparam logic [PRF_IDX-1:0] ZERO_IDX = PRF_IDX'(ZERO_REG);

   logic [XLEN-1:0]              mem_q [PRF_DEPTH];
   logic [XLEN-1:0]              mem_d [PRF_DEPTH];
   logic [PRF_DEPTH-1:0]         rdy_q, rdy_d;
   logic [PRF_DEPTH-1:0]         ent_hit;
   logic [XLEN-1:0]              ent_data [PRF_DEPTH];
   logic [NUM_RD-1:0]            fwd_hit;
   logic [XLEN-1:0]              fwd_data [NUM_RD];
   logic [NUM_RD-1:0][XLEN-1:0]  rd_data_q, rd_data_d;
   logic [NUM_RD-1:0]            rd_rdy_q, rd_rdy_d;
   logic                         wr_conflict_q, wr_conflict_d;
`ifdef PRF_PARITY_EN
   logic [PRF_DEPTH-1:0]         par_q, par_d;
   logic [NUM_RD-1:0]            rd_perr_q, rd_perr_d;
`endif

   for (genvar e = 0; e < PRF_DEPTH; e++) begin : g_ent
      prf_wr_sel #(.XLEN(XLEN), .NUM_WR(NUM_WR), .PRF_IDX(PRF_IDX)) u_sel (
         .addr    (PRF_IDX'(e)),
         .wr_en   (wr_en),
         .wr_addr (wr_addr),
         .wr_data (wr_data),
         .hit     (ent_hit[e]),
         .data    (ent_data[e])
      );
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      prf_wr_sel #(.XLEN(XLEN), .NUM_WR(NUM_WR), .PRF_IDX(PRF_IDX)) u_sel (
         .addr    (rd_addr[i]),
         .wr_en   (wr_en),
         .wr_addr (wr_addr),
         .wr_data (wr_data),
         .hit     (fwd_hit[i]),
         .data    (fwd_data[i])
      );
   end

   // array and scoreboard update: write sets ready, alloc clears it, flush sets all
   always_comb begin
      logic we;
      logic al;
      we    = 1'b0;
      al    = 1'b0;
      mem_d = mem_q;
      rdy_d = rdy_q;
`ifdef PRF_PARITY_EN
      par_d = par_q;
`endif
      for (int e = 0; e < PRF_DEPTH; e++) begin
         we = ent_hit[e] && (e != 0);
         al = 1'b0;
         for (int k = 0; k < NUM_ALLOC; k++) begin
            al = al | (alloc_en[k] && (alloc_addr[k] == PRF_IDX'(e)));
         end
         mem_d[e] = we ? ent_data[e] : mem_q[e];
`ifdef PRF_PARITY_EN
         par_d[e] = we ? (^ent_data[e]) : par_q[e];
`endif
         rdy_d[e] = (e == 0) | flush | (~al & (we | rdy_q[e]));
      end
   end

   // pairwise address compare across enabled writeback ports
   always_comb begin
      wr_conflict_d = 1'b0;
      for (int i = 0; i < NUM_WR; i++) begin
         for (int j = i + 1; j < NUM_WR; j++) begin
            wr_conflict_d = wr_conflict_d |
                            (wr_en[i] & wr_en[j] & (wr_addr[i] == wr_addr[j]));
         end
      end
   end

   // read stage: zero register, then same-cycle write forwarding, then stored state
   always_comb begin
      logic is_zero;
      logic al;
      is_zero   = 1'b0;
      al        = 1'b0;
      rd_data_d = '0;
      rd_rdy_d  = '0;
`ifdef PRF_PARITY_EN
      rd_perr_d = '0;
`endif
      for (int i = 0; i < NUM_RD; i++) begin
         is_zero = (rd_addr[i] == ZERO_IDX);
         al      = 1'b0;
         for (int k = 0; k < NUM_ALLOC; k++) begin
            al = al | (alloc_en[k] && (alloc_addr[k] == rd_addr[i]));
         end
         rd_data_d[i] = is_zero    ? '0 :
                        fwd_hit[i] ? fwd_data[i] : mem_q[rd_addr[i]];
         rd_rdy_d[i]  = is_zero | fwd_hit[i] | flush | (~al & rdy_q[rd_addr[i]]);
`ifdef PRF_PARITY_EN
         rd_perr_d[i] = ~is_zero & ~fwd_hit[i] &
                        ((^mem_q[rd_addr[i]]) ^ par_q[rd_addr[i]]);
`endif
      end
   end

   // scoreboard and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q         <= '1;
         rd_data_q     <= '0;
         rd_rdy_q      <= '0;
         wr_conflict_q <= 1'b0;
`ifdef PRF_PARITY_EN
         rd_perr_q     <= '0;
`endif
      end else begin
         rdy_q         <= rdy_d;
         rd_data_q     <= rd_data_d;
         rd_rdy_q      <= rd_rdy_d;
         wr_conflict_q <= wr_conflict_d;
`ifdef PRF_PARITY_EN
         rd_perr_q     <= rd_perr_d;
`endif
      end
   end

   // data (and parity) storage carries no reset
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
`ifdef PRF_PARITY_EN
      par_q <= par_d;
`endif
   end

   assign rd_data     = rd_data_q;
   assign rd_rdy      = rd_rdy_q;
   assign wr_conflict = wr_conflict_q;
`ifdef PRF_PARITY_EN
   assign rd_perr     = rd_perr_q;
`endif

endmodule

// File: tb/tb_prf_scbd.sv
// Self-checking bench for prf_scbd: directed vector table, hand sequences, and random traffic
// compared against a behavioural register-file model.
module tb_prf_scbd;

   localparam int XLEN  = 64;
   localparam int DEPTH = 64;
   localparam int NRD   = 4;
   localparam int NWR   = 2;
   localparam int NAL   = 2;
   localparam int IDX   = 6;

   logic                       clk = 1'b0;
   logic                       rst_n = 1'b0;
   logic [NRD-1:0][IDX-1:0]    rd_addr;
   logic [NRD-1:0][XLEN-1:0]   rd_data;
   logic [NRD-1:0]             rd_rdy;
   logic [NWR-1:0]             wr_en;
   logic [NWR-1:0][IDX-1:0]    wr_addr;
   logic [NWR-1:0][XLEN-1:0]   wr_data;
   logic [NAL-1:0]             alloc_en;
   logic [NAL-1:0][IDX-1:0]    alloc_addr;
   logic                       flush;
   logic                       wr_conflict;
`ifdef PRF_PARITY_EN
   logic [NRD-1:0]             rd_perr;
`endif

   prf_scbd #(.XLEN(XLEN), .PRF_DEPTH(DEPTH), .NUM_RD(NRD), .NUM_WR(NWR), .NUM_ALLOC(NAL)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .rd_rdy      (rd_rdy),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .alloc_en    (alloc_en),
      .alloc_addr  (alloc_addr),
      .flush       (flush),
      .wr_conflict (wr_conflict)
`ifdef PRF_PARITY_EN
      ,
      .rd_perr     (rd_perr)
`endif
   );

   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   // reference state: register contents and ready bits
   logic [XLEN-1:0] mem_m [DEPTH];
   logic            rdy_m [DEPTH];

   typedef struct {
      logic            w0e; logic [IDX-1:0] w0a; logic [XLEN-1:0] w0d;
      logic            w1e; logic [IDX-1:0] w1a; logic [XLEN-1:0] w1d;
      logic            a0e; logic [IDX-1:0] a0a;
      logic            a1e; logic [IDX-1:0] a1a;
      logic            fl;  logic [IDX-1:0] ra;
      logic [XLEN-1:0] ed;  logic            er;  logic ec;
   } vec_t;
   vec_t vq[$];

   task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      rd_addr    = '0;
      wr_en      = '0;
      wr_addr    = '0;
      wr_data    = '0;
      alloc_en   = '0;
      alloc_addr = '0;
      flush      = 1'b0;
   endtask

   task automatic add(input logic w0e, input logic [IDX-1:0] w0a, input logic [XLEN-1:0] w0d,
                      input logic w1e, input logic [IDX-1:0] w1a, input logic [XLEN-1:0] w1d,
                      input logic a0e, input logic [IDX-1:0] a0a,
                      input logic a1e, input logic [IDX-1:0] a1a,
                      input logic fl, input logic [IDX-1:0] ra,
                      input logic [XLEN-1:0] ed, input logic er, input logic ec);
      vec_t v;
      v.w0e = w0e; v.w0a = w0a; v.w0d = w0d;
      v.w1e = w1e; v.w1a = w1a; v.w1d = w1d;
      v.a0e = a0e; v.a0a = a0a; v.a1e = a1e; v.a1a = a1a;
      v.fl = fl; v.ra = ra; v.ed = ed; v.er = er; v.ec = ec;
      vq.push_back(v);
   endtask

   // one clock: predict from the model, clock the DUT, compare, then advance the model
   task automatic step();
      logic [XLEN-1:0] exp_d [NRD];
      logic            exp_r [NRD];
      logic            exp_c;
      logic            fw;
      logic            al;
      logic [XLEN-1:0] fd;
      for (int i = 0; i < NRD; i++) begin
         fw = 1'b0; fd = '0; al = 1'b0;
         for (int j = 0; j < NWR; j++)
            if (wr_en[j] && wr_addr[j] == rd_addr[i]) begin fw = 1'b1; fd = wr_data[j]; end
         for (int k = 0; k < NAL; k++)
            if (alloc_en[k] && alloc_addr[k] == rd_addr[i]) al = 1'b1;
         if (rd_addr[i] == '0) begin
            exp_d[i] = '0; exp_r[i] = 1'b1;
         end else if (fw) begin
            exp_d[i] = fd; exp_r[i] = 1'b1;
         end else begin
            exp_d[i] = mem_m[rd_addr[i]];
            exp_r[i] = flush ? 1'b1 : (al ? 1'b0 : rdy_m[rd_addr[i]]);
         end
      end
      exp_c = 1'b0;
      for (int a = 0; a < NWR; a++)
         for (int b = a + 1; b < NWR; b++)
            if (wr_en[a] && wr_en[b] && wr_addr[a] == wr_addr[b]) exp_c = 1'b1;

      @(posedge clk); #1;
      for (int i = 0; i < NRD; i++) begin
         check($sformatf("rd_data[%0d]", i), rd_data[i], exp_d[i]);
         check($sformatf("rd_rdy[%0d]", i), {63'd0, rd_rdy[i]}, {63'd0, exp_r[i]});
`ifdef PRF_PARITY_EN
         check($sformatf("rd_perr[%0d]", i), {63'd0, rd_perr[i]}, 64'd0);
`endif
      end
      check("wr_conflict", {63'd0, wr_conflict}, {63'd0, exp_c});

      for (int j = 0; j < NWR; j++)
         if (wr_en[j] && wr_addr[j] != '0) begin
            mem_m[wr_addr[j]] = wr_data[j];
            rdy_m[wr_addr[j]] = 1'b1;
         end
      for (int k = 0; k < NAL; k++)
         if (alloc_en[k] && alloc_addr[k] != '0 && !flush) rdy_m[alloc_addr[k]] = 1'b0;
      if (flush)
         for (int e = 0; e < DEPTH; e++) rdy_m[e] = 1'b1;
   endtask

   initial begin
      idle();
      for (int e = 0; e < DEPTH; e++) begin
         mem_m[e] = (e == 0) ? 64'd0 : 64'h1000 + 64'(e);
         rdy_m[e] = 1'b1;
      end

      // reset held for three cycles
      repeat (3) @(posedge clk);
      #1;
      check("reset_rd_rdy", {60'd0, rd_rdy}, 64'd0);
      for (int i = 0; i < NRD; i++) check($sformatf("reset_rd_data[%0d]", i), rd_data[i], 64'd0);
      check("reset_wr_conflict", {63'd0, wr_conflict}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // preload every register with a known value
      for (int e = 1; e < DEPTH; e += 2) begin
         idle();
         wr_en[0] = 1'b1; wr_addr[0] = IDX'(e); wr_data[0] = mem_m[e];
         if (e + 1 < DEPTH) begin
            wr_en[1] = 1'b1; wr_addr[1] = IDX'(e + 1); wr_data[1] = mem_m[e + 1];
         end
         step();
      end

      //   w0e  w0a  w0d            w1e  w1a  w1d   a0e a0a  a1e a1a  fl   ra   ed          er   ec
      add(1'b1, 6'd7,  64'hDEAD, 1'b0, 6'd0,  64'h0,  1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd5,  64'h1005, 1'b1, 1'b0);
      add(1'b0, 6'd0,  64'h0,    1'b0, 6'd0,  64'h0,  1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd7,  64'hDEAD, 1'b1, 1'b0);
      add(1'b0, 6'd0,  64'h0,    1'b1, 6'd9,  64'h55, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd9,  64'h55,   1'b1, 1'b0);
      add(1'b1, 6'd9,  64'h11,   1'b1, 6'd9,  64'h22, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd9,  64'h22,   1'b1, 1'b1);
      add(1'b0, 6'd0,  64'h0,    1'b0, 6'd0,  64'h0,  1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd9,  64'h22,   1'b1, 1'b0);
      add(1'b0, 6'd0,  64'h0,    1'b0, 6'd0,  64'h0,  1'b1, 6'd12, 1'b0, 6'd0,  1'b0, 6'd1,  64'h1001, 1'b1, 1'b0);
      add(1'b0, 6'd0,  64'h0,    1'b0, 6'd0,  64'h0,  1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd12, 64'h100C, 1'b0, 1'b0);
      add(1'b1, 6'd12, 64'h3,    1'b0, 6'd0,  64'h0,  1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd2,  64'h1002, 1'b1, 1'b0);
      add(1'b0, 6'd0,  64'h0,    1'b0, 6'd0,  64'h0,  1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd12, 64'h3,    1'b1, 1'b0);
      add(1'b0, 6'd0,  64'h0,    1'b1, 6'd12, 64'h4,  1'b0, 6'd0,  1'b1, 6'd12, 1'b0, 6'd12, 64'h4,    1'b1, 1'b0);
      add(1'b0, 6'd0,  64'h0,    1'b0, 6'd0,  64'h0,  1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd12, 64'h4,    1'b0, 1'b0);
      add(1'b0, 6'd0,  64'h0,    1'b0, 6'd0,  64'h0,  1'b1, 6'd3,  1'b1, 6'd4,  1'b0, 6'd6,  64'h1006, 1'b1, 1'b0);
      add(1'b0, 6'd0,  64'h0,    1'b0, 6'd0,  64'h0,  1'b1, 6'd6,  1'b0, 6'd0,  1'b1, 6'd3,  64'h1003, 1'b1, 1'b0);
      add(1'b0, 6'd0,  64'h0,    1'b0, 6'd0,  64'h0,  1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd4,  64'h1004, 1'b1, 1'b0);
      add(1'b0, 6'd0,  64'h0,    1'b0, 6'd0,  64'h0,  1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd6,  64'h1006, 1'b1, 1'b0);
      add(1'b1, 6'd0,  64'hFF,   1'b0, 6'd0,  64'h0,  1'b0, 6'd0,  1'b1, 6'd0,  1'b0, 6'd0,  64'h0,    1'b1, 1'b0);
      add(1'b0, 6'd0,  64'h0,    1'b0, 6'd0,  64'h0,  1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd0,  64'h0,    1'b1, 1'b0);
      add(1'b0, 6'd0,  64'h0,    1'b0, 6'd0,  64'h0,  1'b1, 6'd20, 1'b0, 6'd0,  1'b0, 6'd20, 64'h1014, 1'b0, 1'b0);
      add(1'b0, 6'd0,  64'h0,    1'b0, 6'd0,  64'h0,  1'b1, 6'd21, 1'b0, 6'd0,  1'b1, 6'd21, 64'h1015, 1'b1, 1'b0);
      add(1'b1, 6'd22, 64'h77,   1'b0, 6'd0,  64'h0,  1'b0, 6'd0,  1'b1, 6'd22, 1'b0, 6'd22, 64'h77,   1'b1, 1'b0);
      add(1'b0, 6'd0,  64'h0,    1'b0, 6'd0,  64'h0,  1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 6'd22, 64'h77,   1'b0, 1'b0);

      foreach (vq[n]) begin
         idle();
         wr_en[0] = vq[n].w0e; wr_addr[0] = vq[n].w0a; wr_data[0] = vq[n].w0d;
         wr_en[1] = vq[n].w1e; wr_addr[1] = vq[n].w1a; wr_data[1] = vq[n].w1d;
         alloc_en[0] = vq[n].a0e; alloc_addr[0] = vq[n].a0a;
         alloc_en[1] = vq[n].a1e; alloc_addr[1] = vq[n].a1a;
         flush = vq[n].fl; rd_addr[0] = vq[n].ra;
         step();
         check($sformatf("vec%0d_data", n), rd_data[0], vq[n].ed);
         check($sformatf("vec%0d_rdy", n), {63'd0, rd_rdy[0]}, {63'd0, vq[n].er});
         check($sformatf("vec%0d_conflict", n), {63'd0, wr_conflict}, {63'd0, vq[n].ec});
      end

`ifdef PRF_PARITY_EN
      // corrupt one stored bit of p8 behind the design's back
      idle();
      dut.mem_q[8][0] = ~dut.mem_q[8][0];
      rd_addr[0] = 6'd8;
      @(posedge clk); #1;
      check("parity_p8_perr", {63'd0, rd_perr[0]}, 64'd1);
      idle();
      wr_en[0] = 1'b1; wr_addr[0] = 6'd8; wr_data[0] = mem_m[8]; rd_addr[1] = 6'd8;
      step();
`endif

      // reset asserted mid-cycle while outputs are non-zero
      idle();
      rd_addr[0] = 6'd7;
      wr_en = 2'b11; wr_addr[0] = 6'd30; wr_addr[1] = 6'd30; wr_data[0] = 64'h1; wr_data[1] = 64'h2;
      step();
      idle();
      #2;
      rst_n = 1'b0;
      #1;
      check("midreset_rd_data0", rd_data[0], 64'd0);
      check("midreset_rd_rdy", {60'd0, rd_rdy}, 64'd0);
      check("midreset_wr_conflict", {63'd0, wr_conflict}, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 0; e < DEPTH; e++) rdy_m[e] = 1'b1;
      rd_addr[0] = 6'd30; rd_addr[1] = 6'd12; rd_addr[2] = 6'd22;
      step();
      check("post_reset_p30", rd_data[0], 64'h2);

      // random traffic, addresses biased to a small window to provoke collisions
      for (int t = 0; t < 800; t++) begin
         idle();
         for (int j = 0; j < NWR; j++) begin
            wr_en[j]   = ($urandom_range(0, 1) == 1);
            wr_addr[j] = IDX'($urandom_range(0, 3) == 0 ? $urandom_range(0, 63) : $urandom_range(0, 11));
            wr_data[j] = {$urandom, $urandom};
         end
         for (int k = 0; k < NAL; k++) begin
            alloc_en[k]   = ($urandom_range(0, 2) == 0);
            alloc_addr[k] = IDX'($urandom_range(0, 11));
         end
         flush = ($urandom_range(0, 11) == 0);
         for (int i = 0; i < NRD; i++)
            rd_addr[i] = IDX'($urandom_range(0, 3) == 0 ? $urandom_range(0, 63) : $urandom_range(0, 11));
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
